// File: rtl/rx_udp_demux_pkg.sv
// Shared state encodings and header layout
// for the UDP receive demultiplexer.
package rx_udp_demux_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    localparam logic [2:0] HDR_DST_LO  = 3'd3;
    localparam logic [2:0] HDR_CSUM_LO = 3'd7;

    localparam logic [1:0] FLD_SRC  = 2'd0;
    localparam logic [1:0] FLD_DST  = 2'd1;
    localparam logic [1:0] FLD_LEN  = 2'd2;
    localparam logic [1:0] FLD_CSUM = 2'd3;

    function automatic logic [15:0] fld_shift(
        input logic [15:0] old,
        input logic [7:0]  b
    );
        return {old[7:0], b};
    endfunction

endpackage

// File: rtl/rx_udp_demux_port_match.sv
// Destination-port filter bank with
// lowest-index-wins channel selection.
module udp_port_match #(
    parameter int NPORT = 4,
    parameter int CHW   = 2
) (
    input  logic [15:0]         dst,
    input  logic [NPORT*16-1:0] port_list,
    input  logic [NPORT-1:0]    port_en,
    output logic                hit,
    output logic [CHW-1:0]      ch
);

    always_comb begin
        hit = 1'b0;
        ch  = '0;
        // Walk downwards so the lowest matching index is written last.
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (port_en[k] && port_list[16*k +: 16] == dst) begin
                hit = 1'b1;
                ch  = CHW'(k);
            end
        end
    end

endmodule

// File: rtl/rx_udp_demux.sv
// UDP header parser and per-port payload
// demultiplexer on the IPv4 receive stream.
module rx_udp_demux
    import rx_udp_demux_pkg::*;
#(
    parameter int OCT   = 8,
    parameter int NPORT = 4,
    parameter int CHW   = 2
) (
    input  logic                RX_CLK,
    input  logic                rst,
    input  logic                func_en,
    input  logic [NPORT*16-1:0] port_list,
    input  logic [NPORT-1:0]    port_en,
    input  logic                rx_data_v,
    input  logic [OCT-1:0]      rx_data,
    output logic [15:0]         rx_src_port,
    output logic [15:0]         rx_dst_port,
    output logic [15:0]         rx_data_len,
    output logic [15:0]         rx_checksum,
    output logic                rx_udp_data_v,
    output logic [OCT-1:0]      rx_udp_data,
    output logic                rx_udp_last,
    output logic [CHW-1:0]      rx_udp_ch,
    output logic                rx_udp_irq,
    output logic                rx_udp_drop,
    output logic                rx_len_err
);

    logic [1:0]     state_q, state_d;
    logic [2:0]     hdr_cnt_q, hdr_cnt_d;
    logic [15:0]    pay_cnt_q, pay_cnt_d;
    logic           v_prev_q;
    logic [15:0]    src_q, src_d, dst_q, dst_d;
    logic [15:0]    len_q, len_d, csum_q, csum_d;
    logic           hit_q, hit_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic           udp_v_q, udp_v_d;
    logic [OCT-1:0] udp_data_q, udp_data_d;
    logic           last_q, last_d;
    logic           irq_q, irq_d;
    logic           drop_q, drop_d;
    logic           len_err_q, len_err_d;

    logic           hdr_en;
    logic [2:0]     hdr_idx;
    logic [7:0]     hb;
    logic           m_hit;
    logic [CHW-1:0] m_ch;

    assign hb = rx_data[7:0];

    udp_port_match #(
        .NPORT (NPORT),
        .CHW   (CHW)
    ) u_match (
        .dst       (dst_d),
        .port_list (port_list),
        .port_en   (port_en),
        .hit       (m_hit),
        .ch        (m_ch)
    );

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        pay_cnt_d  = pay_cnt_q;
        udp_v_d    = 1'b0;
        udp_data_d = udp_data_q;
        last_d     = 1'b0;
        irq_d      = udp_v_q & last_q;
        drop_d     = 1'b0;
        len_err_d  = 1'b0;
        hdr_en     = 1'b0;
        hdr_idx    = hdr_cnt_q;
        if (func_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Only a rising valid starts a datagram, so a
                    // stream cut by reset is skipped to its end.
                    if (rx_data_v && !v_prev_q) begin
                        hdr_en    = 1'b1;
                        hdr_idx   = 3'd0;
                        hdr_cnt_d = 3'd1;
                        state_d   = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!rx_data_v) begin
                        len_err_d = 1'b1;
                        hdr_cnt_d = 3'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        hdr_en    = 1'b1;
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                        if (hdr_cnt_q == HDR_CSUM_LO) begin
                            state_d = ST_DRAIN;
                            if (len_q < UDP_HDR_LEN) begin
                                len_err_d = 1'b1;
                            end else if (!hit_q) begin
                                drop_d = 1'b1;
                            end else if (len_q == UDP_HDR_LEN) begin
                                irq_d = 1'b1;
                            end else begin
                                state_d   = ST_DATA;
                                pay_cnt_d = len_q - UDP_HDR_LEN;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (!rx_data_v) begin
                        len_err_d = 1'b1;
                        pay_cnt_d = 16'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        udp_v_d    = 1'b1;
                        udp_data_d = rx_data;
                        pay_cnt_d  = pay_cnt_q - 16'd1;
                        if (pay_cnt_q == 16'd1) begin
                            last_d  = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end
                end
                default: begin
                    if (!rx_data_v) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end else begin
            state_d   = ST_IDLE;
            hdr_cnt_d = 3'd0;
            pay_cnt_d = 16'd0;
            irq_d     = 1'b0;
        end
    end

    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        csum_d = csum_q;
        hit_d  = hit_q;
        ch_d   = ch_q;
        if (hdr_en) begin
            unique case (hdr_idx[2:1])
                FLD_SRC:  src_d  = fld_shift(src_q, hb);
                FLD_DST:  dst_d  = fld_shift(dst_q, hb);
                FLD_LEN:  len_d  = fld_shift(len_q, hb);
                FLD_CSUM: csum_d = fld_shift(csum_q, hb);
            endcase
            if (hdr_idx == HDR_DST_LO) begin
                hit_d = m_hit;
                ch_d  = m_ch;
            end
        end
    end

    always_ff @(posedge RX_CLK) begin
        v_prev_q <= rx_data_v;
        if (rst) begin
            state_q    <= ST_IDLE;
            hdr_cnt_q  <= 3'd0;
            pay_cnt_q  <= 16'd0;
            src_q      <= 16'd0;
            dst_q      <= 16'd0;
            len_q      <= 16'd0;
            csum_q     <= 16'd0;
            hit_q      <= 1'b0;
            ch_q       <= '0;
            udp_v_q    <= 1'b0;
            udp_data_q <= '0;
            last_q     <= 1'b0;
            irq_q      <= 1'b0;
            drop_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            hit_q      <= hit_d;
            ch_q       <= ch_d;
            udp_v_q    <= udp_v_d;
            udp_data_q <= udp_data_d;
            last_q     <= last_d;
            irq_q      <= irq_d;
            drop_q     <= drop_d;
            len_err_q  <= len_err_d;
        end
    end

    assign rx_src_port   = src_q;
    assign rx_dst_port   = dst_q;
    assign rx_data_len   = len_q;
    assign rx_checksum   = csum_q;
    assign rx_udp_data_v = udp_v_q;
    assign rx_udp_data   = udp_data_q;
    assign rx_udp_last   = last_q;
    assign rx_udp_ch     = ch_q;
    assign rx_udp_irq    = irq_q;
    assign rx_udp_drop   = drop_q;
    assign rx_len_err    = len_err_q;

endmodule

// File: tb/tb_rx_udp_demux.sv
// Randomised and directed bench for rx_udp_demux
// against a datagram-level reference model.
module tb_rx_udp_demux;

    localparam int OCT   = 8;
    localparam int NPORT = 4;
    localparam int CHW   = 2;

    logic                RX_CLK = 1'b0;
    logic                rst;
    logic                func_en;
    logic [NPORT*16-1:0] port_list;
    logic [NPORT-1:0]    port_en;
    logic                rx_data_v;
    logic [OCT-1:0]      rx_data;
    logic [15:0]         rx_src_port, rx_dst_port;
    logic [15:0]         rx_data_len, rx_checksum;
    logic                rx_udp_data_v, rx_udp_last;
    logic [OCT-1:0]      rx_udp_data;
    logic [CHW-1:0]      rx_udp_ch;
    logic                rx_udp_irq, rx_udp_drop, rx_len_err;

    rx_udp_demux #(
        .OCT   (OCT),
        .NPORT (NPORT),
        .CHW   (CHW)
    ) dut (
        .RX_CLK        (RX_CLK),
        .rst           (rst),
        .func_en       (func_en),
        .port_list     (port_list),
        .port_en       (port_en),
        .rx_data_v     (rx_data_v),
        .rx_data       (rx_data),
        .rx_src_port   (rx_src_port),
        .rx_dst_port   (rx_dst_port),
        .rx_data_len   (rx_data_len),
        .rx_checksum   (rx_checksum),
        .rx_udp_data_v (rx_udp_data_v),
        .rx_udp_data   (rx_udp_data),
        .rx_udp_last   (rx_udp_last),
        .rx_udp_ch     (rx_udp_ch),
        .rx_udp_irq    (rx_udp_irq),
        .rx_udp_drop   (rx_udp_drop),
        .rx_len_err    (rx_len_err)
    );

    always #5 RX_CLK = ~RX_CLK;

    int cyc = 0;
    always @(posedge RX_CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]     d;
        logic           last;
        logic [CHW-1:0] ch;
        int             cyc;
    } beat_t;

    beat_t beats[$];
    int    irqs[$];
    int    drops[$];
    int    lerrs[$];
    logic [7:0] dg[$];
    int    dcyc[$];
    int    n_chk = 0;
    int    n_fail = 0;

    always @(negedge RX_CLK) begin
        if (rx_udp_data_v)
            beats.push_back('{rx_udp_data, rx_udp_last, rx_udp_ch, cyc});
        if (rx_udp_irq) irqs.push_back(cyc);
        if (rx_udp_drop) drops.push_back(cyc);
        if (rx_len_err) lerrs.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        beats.delete();
        irqs.delete();
        drops.delete();
        lerrs.delete();
    endtask

    task automatic build(input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [15:0] c,
                         input int extra);
        dg.delete();
        dg.push_back(s[15:8]); dg.push_back(s[7:0]);
        dg.push_back(d[15:8]); dg.push_back(d[7:0]);
        dg.push_back(l[15:8]); dg.push_back(l[7:0]);
        dg.push_back(c[15:8]); dg.push_back(c[7:0]);
        for (int i = 0; i < extra; i++) dg.push_back(8'($urandom));
    endtask

    task automatic drive(input int n);
        dcyc.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge RX_CLK); #1;
            rx_data_v = 1'b1;
            rx_data   = dg[i];
            dcyc.push_back(cyc);
        end
        @(posedge RX_CLK); #1;
        rx_data_v = 1'b0;
        rx_data   = 8'($urandom);
        repeat (4) @(posedge RX_CLK);
        #1;
    endtask

    // Reference: what a complete run of n driven bytes must produce.
    task automatic run_check(input string tag, input int n);
        logic [15:0] src, dst, len, csum;
        bit hit = 0;
        int ch = 0, nb = 0, e_irq = 0, e_drop = 0, e_lerr = 0;
        int ec;
        if (n < 8) begin
            e_lerr = 1;
        end else begin
            src  = {dg[0], dg[1]};
            dst  = {dg[2], dg[3]};
            len  = {dg[4], dg[5]};
            csum = {dg[6], dg[7]};
            for (int j = NPORT - 1; j >= 0; j--)
                if (port_en[j] && port_list[16*j +: 16] == dst) begin
                    hit = 1;
                    ch  = j;
                end
            if (len < 8) e_lerr = 1;
            else if (!hit) e_drop = 1;
            else if (n - 8 >= int'(len) - 8) begin
                nb = int'(len) - 8;
                e_irq = 1;
            end else begin
                nb = n - 8;
                e_lerr = 1;
            end
            chk({tag, "_src"}, rx_src_port, src);
            chk({tag, "_dst"}, rx_dst_port, dst);
            chk({tag, "_len"}, rx_data_len, len);
            chk({tag, "_csum"}, rx_checksum, csum);
        end
        chk({tag, "_nbeat"}, beats.size(), nb);
        chk({tag, "_nirq"}, irqs.size(), e_irq);
        chk({tag, "_ndrop"}, drops.size(), e_drop);
        chk({tag, "_nlerr"}, lerrs.size(), e_lerr);
        for (int j = 0; j < nb && j < beats.size(); j++) begin
            chk({tag, "_data"}, beats[j].d, dg[8+j]);
            chk({tag, "_last"}, beats[j].last, (j == nb - 1) && e_irq);
            chk({tag, "_ch"}, beats[j].ch, ch);
            chk({tag, "_lat"}, beats[j].cyc, dcyc[8+j] + 1);
        end
        if (e_irq && irqs.size() == 1) begin
            ec = (nb > 0) ? dcyc[8+nb-1] + 2 : dcyc[7] + 1;
            chk({tag, "_irqcyc"}, irqs[0], ec);
        end
        clr();
    endtask

    logic [15:0] sv_src, sv_dst, sv_len, sv_csum;

    initial begin
        rst       = 1'b1;
        func_en   = 1'b1;
        rx_data_v = 1'b0;
        rx_data   = '0;
        port_en   = '0;
        port_list = '0;
        repeat (3) @(posedge RX_CLK);
        #1;
        chk("rst_src", rx_src_port, 0);
        chk("rst_dst", rx_dst_port, 0);
        chk("rst_len", rx_data_len, 0);
        chk("rst_csum", rx_checksum, 0);
        chk("rst_v", rx_udp_data_v, 0);
        chk("rst_last", rx_udp_last, 0);
        chk("rst_ch", rx_udp_ch, 0);
        chk("rst_pulses", {rx_udp_irq, rx_udp_drop, rx_len_err}, 0);
        rst = 1'b0;
        clr();

        port_list = {16'h0003, 16'h1234, 16'h0002, 16'h0001};
        port_en   = 4'b0100;
        build(16'hABCD, 16'h1234, 16'h000C, 16'hBEEF, 4);
        drive(12);
        run_check("t1", 12);

        build(16'h0101, 16'h1234, 16'h000A, 16'h0000, 22);
        drive(30);
        run_check("t2_pad", 30);

        build(16'h0202, 16'h5555, 16'h000C, 16'h1111, 4);
        drive(12);
        run_check("t3_drop", 12);

        port_list = {16'h0050, 16'h0052, 16'h0051, 16'h0050};
        port_en   = 4'b1001;
        build(16'h0303, 16'h0050, 16'h0009, 16'h2222, 1);
        drive(9);
        run_check("t4_prio0", 9);
        port_en = 4'b1000;
        build(16'h0404, 16'h0050, 16'h0009, 16'h3333, 1);
        drive(9);
        run_check("t4_prio3", 9);

        build(16'h0505, 16'h0050, 16'h0004, 16'h4444, 2);
        drive(10);
        run_check("t5_short", 10);
        build(16'h0606, 16'h0050, 16'h0010, 16'h5555, 8);
        drive(11);
        run_check("t5_trunc", 11);

        build(16'h0707, 16'h0050, 16'h0010, 16'h6666, 8);
        for (int i = 0; i < 10; i++) begin
            @(posedge RX_CLK); #1;
            rx_data_v = 1'b1;
            rx_data   = dg[i];
        end
        @(posedge RX_CLK); #1;
        rst = 1'b1; rx_data = dg[10];
        @(posedge RX_CLK); #1;
        clr();
        rx_data = dg[11];
        @(posedge RX_CLK); #1;
        chk("t6_rst_v", rx_udp_data_v, 0);
        chk("t6_rst_src", rx_src_port, 0);
        rst = 1'b0; rx_data = dg[12];
        for (int i = 13; i < 16; i++) begin
            @(posedge RX_CLK); #1;
            rx_data = dg[i];
        end
        @(posedge RX_CLK); #1;
        rx_data_v = 1'b0;
        repeat (4) @(posedge RX_CLK);
        #1;
        chk("t6_rst_quiet",
            beats.size() + irqs.size() + drops.size() + lerrs.size(), 0);
        clr();
        build(16'h0808, 16'h0050, 16'h000B, 16'h7777, 3);
        drive(11);
        run_check("t6_after", 11);

        sv_src = rx_src_port; sv_dst = rx_dst_port;
        sv_len = rx_data_len; sv_csum = rx_checksum;
        func_en = 1'b0;
        build(16'h0909, 16'h0050, 16'h000C, 16'h8888, 4);
        drive(12);
        chk("t6_fe_quiet",
            beats.size() + irqs.size() + drops.size() + lerrs.size(), 0);
        chk("t6_fe_hdr", {rx_src_port, rx_dst_port}, {sv_src, sv_dst});
        chk("t6_fe_len", {rx_data_len, rx_checksum}, {sv_len, sv_csum});
        func_en = 1'b1;
        clr();

        for (int it = 0; it < 40; it++) begin
            logic [15:0] p, dst, len;
            int ki, pay, tot, n;
            for (int k = 0; k < NPORT; k++) begin
                case ($urandom_range(0, 3))
                    0: p = 16'h0050;
                    1: p = 16'h1234;
                    2: p = 16'h8000;
                    default: p = 16'($urandom);
                endcase
                port_list[16*k +: 16] = p;
            end
            port_en = 4'($urandom);
            ki = $urandom_range(0, NPORT - 1);
            if ($urandom_range(0, 9) < 7) dst = port_list[16*ki +: 16];
            else dst = 16'($urandom);
            if ($urandom_range(0, 3) == 0) len = 16'($urandom_range(0, 7));
            else len = 16'(8 + $urandom_range(0, 12));
            pay = (len >= 8) ? int'(len) - 8 : 0;
            tot = 8 + pay + $urandom_range(0, 4);
            build(16'($urandom), dst, len, 16'($urandom), tot - 8);
            n = tot;
            if ($urandom_range(0, 4) == 0) n = $urandom_range(1, 8 + pay - 1);
            drive(n);
            run_check("rnd", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
